// File: rtl/uart_tx_stage.sv
// uart_tx_stage: asynchronous serial transmitter fed by the CPU stage controller.
// A load strobe accepted in IDLE captures UART_data and sends one frame on txd:
// one start bit (low), DATA_BITS data bits LSB first, STOP_BITS stop bits (high).
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset
//   UART_load - load strobe, accepted only while UART_TE is high
//   UART_data - byte to send, captured on the accepting edge
//   UART_TE   - high when idle and able to accept a load (registered)
//   txd       - serial line, idle high (registered)
//   tx_done   - one-cycle pulse on the edge that ends the last stop bit (registered)
module uart_tx_stage #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 UART_load,
   input  logic [DATA_BITS-1:0] UART_data,
   output logic                 UART_TE,
   output logic                 txd,
   output logic                 tx_done
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = $clog2(DATA_BITS) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   logic [1:0]           state_q, state_d;
   logic [BAUD_W-1:0]    baud_q,  baud_d;
   logic [BIT_W-1:0]     bit_q,   bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 txd_q,   txd_d;
   logic                 te_q,    te_d;
   logic                 done_q,  done_d;

   logic                 bit_end;

   assign UART_TE = te_q;
   assign txd     = txd_q;
   assign tx_done = done_q;

   // Last cycle of the current serial bit period.
   assign bit_end = (baud_q == BAUD_LAST);

   // State register; reset aborts any frame and returns the line high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         te_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         te_q    <= te_d;
         done_q  <= done_d;
      end
   end

   // Next-state and output logic. txd/UART_TE are computed one edge ahead so
   // they come straight from flops.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      te_d    = te_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            te_d  = 1'b1;
            if (UART_load) begin
               shift_d = UART_data;
               state_d = S_START;
               txd_d   = 1'b0;
               te_d    = 1'b0;
               baud_d  = '0;
               bit_d   = '0;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               txd_d   = shift_q[0];
               bit_d   = '0;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == DATA_LAST) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
                  bit_d   = '0;
               end else begin
                  // Next data bit is shift_q[1], which becomes bit 0 after the shift.
                  shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                  txd_d   = shift_q[1];
                  bit_d   = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         S_STOP: begin
            // Bit counter is reused to count stop bits.
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  te_d    = 1'b1;
                  done_d  = 1'b1;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            te_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Scoreboard bench for uart_tx_stage: stimulus pushes expected bytes,
// one monitor per DUT decodes txd and checks every frame cycle by cycle.
module tb_uart_tx_stage;

   localparam int unsigned CPB = 4;

   logic       clk;
   logic       reset;
   logic       ld    [2];
   logic [7:0] dat   [2];
   logic       te_w  [2];
   logic       txd_w [2];
   logic       done_w[2];

   // Expected frames: bit 8 = frame is expected to be aborted by reset.
   logic [8:0] exp_q [2][$];

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_stage #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .UART_load (ld[0]),
      .UART_data (dat[0]),
      .UART_TE   (te_w[0]),
      .txd       (txd_w[0]),
      .tx_done   (done_w[0])
   );

   uart_tx_stage #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .UART_load (ld[1]),
      .UART_data (dat[1]),
      .UART_TE   (te_w[1]),
      .txd       (txd_w[1]),
      .tx_done   (done_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Load strobe held for 'hold' cycles; one frame expected.
   task automatic send(input int d, input logic [7:0] b, input bit abort, input int hold);
      exp_q[d].push_back({abort, b});
      @(posedge clk); #1;
      ld[d]  = 1'b1;
      dat[d] = b;
      repeat (hold) @(posedge clk);
      #1;
      ld[d] = 1'b0;
   endtask

   task automatic wait_te(input int d);
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (te_w[d]) begin
            seen = 1;
            break;
         end
      end
      chk("wait_te_timeout", int'(seen), 1);
   endtask

   // Frame monitors, one per DUT (index 0: one stop bit, index 1: two).
   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam int unsigned TOTAL = (1 + 8 + g + 1) * CPB;
      initial begin : mon
         bit         in_frame;
         bit         rst_prev;
         int         k;
         int         idx;
         int         wave_err;
         logic [8:0] cur;
         logic [7:0] got;
         logic       exp_bit;
         in_frame = 0;
         rst_prev = 1;
         k        = 0;
         wave_err = 0;
         cur      = '0;
         got      = '0;
         forever begin
            @(negedge clk);
            if (!in_frame) begin
               if (te_w[g] == 1'b0 && !rst_prev) begin
                  if (exp_q[g].size() == 0) begin
                     chk("unexpected_frame", 1, 0);
                     cur = '0;
                  end else begin
                     cur = exp_q[g].pop_front();
                  end
                  in_frame = 1;
                  k        = 0;
                  wave_err = 0;
                  got      = '0;
               end else begin
                  chk("idle_txd", int'(txd_w[g]), 1);
                  chk("idle_done", int'(done_w[g]), 0);
               end
            end
            if (in_frame) begin
               if (rst_prev) begin
                  chk("abort_expected", int'(cur[8]), 1);
                  chk("abort_txd", int'(txd_w[g]), 1);
                  chk("abort_te", int'(te_w[g]), 1);
                  chk("abort_wave", wave_err, 0);
                  in_frame = 0;
               end else if (k < int'(TOTAL)) begin
                  idx = k / int'(CPB);
                  if (idx == 0)      exp_bit = 1'b0;
                  else if (idx <= 8) exp_bit = cur[idx-1];
                  else               exp_bit = 1'b1;
                  if (idx >= 1 && idx <= 8 && (k % int'(CPB)) == 2) got[idx-1] = txd_w[g];
                  if (txd_w[g] !== exp_bit || te_w[g] !== 1'b0 || done_w[g] !== 1'b0)
                     wave_err++;
                  k++;
               end else begin
                  chk("te_rise", int'(te_w[g]), 1);
                  chk("tx_done_pulse", int'(done_w[g]), 1);
                  chk("stop_txd", int'(txd_w[g]), 1);
                  chk("frame_wave", wave_err, 0);
                  chk("frame_byte", int'(got), int'(cur[7:0]));
                  chk("not_aborted", int'(cur[8]), 0);
                  in_frame = 0;
               end
            end
            rst_prev = reset;
         end
      end
   end

   initial begin
      reset  = 1'b1;
      ld[0]  = 1'b0;
      ld[1]  = 1'b0;
      dat[0] = '0;
      dat[1] = '0;

      // Reset and idle.
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_te", int'(te_w[0]), 1);
      chk("rst_txd", int'(txd_w[0]), 1);
      chk("rst_done", int'(done_w[0]), 0);
      repeat (50) @(posedge clk);

      // Single frame.
      send(0, 8'hA5, 1'b0, 1);
      chk("accept_te_low", int'(te_w[0]), 0);
      chk("accept_start_bit", int'(txd_w[0]), 0);
      wait_te(0);
      repeat (5) @(posedge clk);

      // Load while busy: FF pulse at cycle 13 must be ignored.
      send(0, 8'h3C, 1'b0, 1);
      repeat (12) @(posedge clk);
      #1;
      ld[0]  = 1'b1;
      dat[0] = 8'hFF;
      @(posedge clk); #1;
      ld[0] = 1'b0;
      wait_te(0);
      repeat (50) @(posedge clk);

      // Back-to-back: second load in the tx_done cycle.
      send(0, 8'h55, 1'b0, 1);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done_w[0]) break;
      end
      chk("b2b_done_seen", int'(done_w[0]), 1);
      exp_q[0].push_back({1'b0, 8'h0F});
      ld[0]  = 1'b1;
      dat[0] = 8'h0F;
      @(posedge clk); #1;
      ld[0] = 1'b0;
      chk("b2b_te_low", int'(te_w[0]), 0);
      wait_te(0);
      repeat (5) @(posedge clk);

      // Reset mid-frame at cycle 17, then a fresh frame.
      send(0, 8'hC3, 1'b1, 1);
      repeat (16) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst_txd", int'(txd_w[0]), 1);
      chk("midrst_te", int'(te_w[0]), 1);
      repeat (3) @(posedge clk);
      send(0, 8'h81, 1'b0, 1);
      wait_te(0);
      repeat (5) @(posedge clk);

      // Reset and load on the same edge: no frame.
      #1;
      reset  = 1'b1;
      ld[0]  = 1'b1;
      dat[0] = 8'h77;
      @(posedge clk); #1;
      reset = 1'b0;
      ld[0] = 1'b0;
      chk("rst_vs_load_te", int'(te_w[0]), 1);
      repeat (50) @(posedge clk);

      // Held load: one frame only.
      send(0, 8'h12, 1'b0, 5);
      wait_te(0);
      repeat (50) @(posedge clk);

      // Two stop bits.
      send(1, 8'h00, 1'b0, 1);
      wait_te(1);
      repeat (20) @(posedge clk);

      chk("queue0_drained", exp_q[0].size(), 0);
      chk("queue1_drained", exp_q[1].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_stage.md
Name: uart_tx_stage

Overview:
Serial transmitter that sits directly downstream of the CPU stage controller and consumes its UART_load strobe during the SEND stage. It captures the byte presented on UART_data when UART_load is high and shifts it out on txd as an 8N1-style asynchronous frame. UART_TE (transmitter empty) is returned to the stage controller, which holds SEND until UART_TE is high.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2 or more.
DATA_BITS, 8, data bits per frame; legal range 5 to 8.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
UART_load  input  1  load strobe from the stage controller; sampled every rising edge
UART_data  input  DATA_BITS  byte to send; captured only on an accepted load
UART_TE  output  1  high = idle and able to accept a load; low = frame in progress
txd  output  1  serial line, idle high; registered output
tx_done  output  1  one-cycle pulse on the edge that completes the last stop bit

Behaviour:
- Reset (reset=1 at a rising edge): state=IDLE, txd=1, UART_TE=1, tx_done=0, baud counter=0, bit counter=0, shift register=0. Reset mid-frame aborts the frame. txd returns high on that same edge and no partial stop bit is sent.
- The block has four states: IDLE, START, DATA and STOP.
- IDLE: txd=1 and UART_TE=1.
  - UART_load=1 at an edge is accepted. On that edge, UART_data is captured into the shift register, the state goes to START, txd=0, UART_TE=0 and baud counter=0.
  - UART_TE is therefore already low in the first SEND cycle of the stage controller.
- START: txd=0 for exactly CLKS_PER_BIT cycles. After that, the state goes to DATA, txd=shift[0] and bit counter=0.
- DATA: each bit is held for CLKS_PER_BIT cycles, LSB first.
  - At each bit boundary the shift register shifts right and the bit counter increments.
  - After bit DATA_BITS-1, the state goes to STOP and txd=1.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final edge of this interval:
  - the state goes to IDLE;
  - UART_TE=1;
  - tx_done=1 for exactly one cycle.
- Frame timing: the rising edge of UART_TE comes exactly (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles after the load-accept edge. With the defaults this is 10*434 = 4340 cycles.
- Baud counter:
  - width is $clog2(CLKS_PER_BIT);
  - it counts 0 to CLKS_PER_BIT-1, then wraps to 0 at each bit boundary;
  - it never overflows.
- Bit counter width is $clog2(DATA_BITS)+1.
- Load while UART_TE=0 (START, DATA or STOP): ignored. UART_data is not captured, the frame in progress is unaffected, and no queueing takes place.
- UART_data changing after the accept edge has no effect on the frame in progress.
- Back-to-back frames:
  - UART_load=1 in the cycle where UART_TE=1 and tx_done=1 is accepted.
  - The next start bit begins on that edge, so there are no idle cycles between frames.
- reset and UART_load high on the same edge: reset wins and the load is discarded.
- A UART_load held high in IDLE for several cycles starts only one frame. The first edge is accepted; the remaining cycles fall while UART_TE=0 and are ignored.
- txd and UART_TE are driven only from flops, with no combinational path from inputs.

Test Plan:
- Reset and idle: reset=1 for 2 cycles then low, no load for 50 cycles -> txd=1, UART_TE=1 and tx_done=0 throughout.
- Single frame:
  - Stimulus: CLKS_PER_BIT=4, load 8'hA5 at edge 0.
  - Required txd, 4 cycles per bit: 0 (start), then 1,0,1,0,0,1,0,1 (LSB first), then 1 (stop).
  - UART_TE is low from edge 0 and rises at edge 40, with tx_done=1 only in that cycle.
- Load while busy: send 8'h3C, pulse UART_load with UART_data=8'hFF at cycle 13 -> the frame is still 3C, UART_TE rises at edge 40, and no second frame is sent.
- Back-to-back: load 8'h55, then load 8'h0F in the tx_done cycle -> the second start bit begins at edge 40, UART_TE stays low until edge 80, and the decoded bytes are 55 then 0F.
- Reset mid-frame: assert reset at cycle 17 of an 8'hC3 frame -> txd=1 and UART_TE=1 on the next edge. A fresh load of 8'h81 afterwards gives a correct full 40-cycle frame.
- Two stop bits: STOP_BITS=2, CLKS_PER_BIT=4, load 8'h00 -> txd low for 36 cycles, then high for 8 cycles, and UART_TE rises at edge 44.
